// File: rtl/cdb_pkg.sv
// Shared types and constants for the CDB writeback slice.
//   cdb_src_e   : source unit that owns a broadcast
//   cdb_pkt_t   : CDB payload at the default codebase widths
//   PRIO_ORDER  : completion arbitration order, highest priority first
//   count_set   : population count of a per-unit flag vector
package cdb_pkg;

  localparam int unsigned CDB_TAG_W  = 6;
  localparam int unsigned CDB_DATA_W = 32;
  localparam int unsigned NUM_SRC    = 4;

  typedef enum logic [1:0] {
    SRC_DIV = 2'd0,
    SRC_MUL = 2'd1,
    SRC_INT = 2'd2,
    SRC_LS  = 2'd3
  } cdb_src_e;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    cdb_src_e              src;
  } cdb_pkt_t;

  localparam cdb_src_e PRIO_ORDER [NUM_SRC] = '{SRC_DIV, SRC_MUL, SRC_INT, SRC_LS};

  // Number of set bits in a per-unit vector (0..NUM_SRC).
  function automatic logic [2:0] count_set(input logic [NUM_SRC-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) n = n + 3'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/cdb_writeback_pipe.sv
// latency_pipe: fixed-depth shift register carrying {valid, tag} of an issued op.
//   clk, rst_b      : clock, async active-low reset
//   clear           : synchronous kill of every valid bit
//   in_valid/in_tag : stage-0 load
//   out_valid/out_tag : stage DEPTH-1, i.e. the op completing this cycle
module latency_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic [DEPTH-1:0] vld;
  logic [TAG_W-1:0] tag_q [DEPTH];

  // Valid bits and tags advance together; clear only needs to drop the valids.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld <= '0;
      for (int i = 0; i < int'(DEPTH); i++) tag_q[i] <= '0;
    end else if (clear) begin
      vld <= '0;
    end else begin
      vld[0]   <= in_valid;
      tag_q[0] <= in_tag;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld[i]   <= vld[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/cdb_writeback.sv
// cdb_writeback: tracks issued tags through per-unit latency pipes and drives one
// registered Common Data Bus broadcast per cycle.
//   clk, rst_b            : clock, async active-low reset
//   flush                 : kill all in-flight ops
//   issue_*/ *_tag        : issue pulses and destination tags (div, mul, int, ls)
//   *_result              : unit results, valid in each unit's completion cycle
//   cdb_valid/tag/data/src: registered broadcast
//   collision_err         : sticky, two or more completions in one cycle
//   inflight_cnt          : ops currently held in the pipes
module cdb_writeback
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_MUL_CYC = 4,
  parameter int unsigned NUM_DIV_CYC = 6,
  parameter int unsigned TAG_W       = 6,
  parameter int unsigned DATA_W      = 32,
  localparam int unsigned CNT_W      = $clog2(NUM_MUL_CYC + NUM_DIV_CYC + 3)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              flush,
  input  logic              issue_div,
  input  logic              issue_mul,
  input  logic              issue_int,
  input  logic              issue_ls,
  input  logic [TAG_W-1:0]  div_tag,
  input  logic [TAG_W-1:0]  mul_tag,
  input  logic [TAG_W-1:0]  int_tag,
  input  logic [TAG_W-1:0]  ls_tag,
  input  logic [DATA_W-1:0] div_result,
  input  logic [DATA_W-1:0] mul_result,
  input  logic [DATA_W-1:0] int_result,
  input  logic [DATA_W-1:0] ls_result,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output cdb_src_e          cdb_src,
  output logic              collision_err,
  output logic [CNT_W-1:0]  inflight_cnt
);

  localparam int unsigned CNT_MAX = NUM_MUL_CYC + NUM_DIV_CYC + 2;

  if (NUM_MUL_CYC < 1 || NUM_DIV_CYC < 1) begin : g_bad_latency
    $error("cdb_writeback: unit latencies must be at least 1");
  end

  logic [NUM_SRC-1:0] iss;
  logic [NUM_SRC-1:0] comp;
  logic [TAG_W-1:0]   comp_tag  [NUM_SRC];
  logic [DATA_W-1:0]  comp_data [NUM_SRC];

  assign iss = {issue_ls, issue_int, issue_mul, issue_div};

  assign comp_data[SRC_DIV] = div_result;
  assign comp_data[SRC_MUL] = mul_result;
  assign comp_data[SRC_INT] = int_result;
  assign comp_data[SRC_LS]  = ls_result;

  latency_pipe #(.DEPTH(NUM_DIV_CYC), .TAG_W(TAG_W)) u_div_pipe (
    .clk(clk), .rst_b(rst_b), .clear(flush), .in_valid(issue_div), .in_tag(div_tag),
    .out_valid(comp[SRC_DIV]), .out_tag(comp_tag[SRC_DIV]));

  latency_pipe #(.DEPTH(NUM_MUL_CYC), .TAG_W(TAG_W)) u_mul_pipe (
    .clk(clk), .rst_b(rst_b), .clear(flush), .in_valid(issue_mul), .in_tag(mul_tag),
    .out_valid(comp[SRC_MUL]), .out_tag(comp_tag[SRC_MUL]));

  latency_pipe #(.DEPTH(1), .TAG_W(TAG_W)) u_int_pipe (
    .clk(clk), .rst_b(rst_b), .clear(flush), .in_valid(issue_int), .in_tag(int_tag),
    .out_valid(comp[SRC_INT]), .out_tag(comp_tag[SRC_INT]));

  latency_pipe #(.DEPTH(1), .TAG_W(TAG_W)) u_ls_pipe (
    .clk(clk), .rst_b(rst_b), .clear(flush), .in_valid(issue_ls), .in_tag(ls_tag),
    .out_valid(comp[SRC_LS]), .out_tag(comp_tag[SRC_LS]));

  // Fixed-priority winner: walk from lowest to highest priority so the highest overwrites.
  logic     win_valid;
  cdb_src_e win_src;

  always_comb begin
    win_valid = 1'b0;
    win_src   = SRC_INT;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (comp[PRIO_ORDER[i]]) begin
        win_valid = 1'b1;
        win_src   = PRIO_ORDER[i];
      end
    end
  end

  logic               collision_c;
  logic [2:0]         n_iss;
  logic [2:0]         n_comp;
  logic [CNT_W+1:0]   cnt_sum;

  // Extra headroom bits so an underflow shows up as a set MSB rather than wrapping.
  always_comb begin
    n_iss       = count_set(iss);
    n_comp      = count_set(comp);
    collision_c = (n_comp > 3'd1);
    cnt_sum     = (CNT_W+2)'(inflight_cnt) + (CNT_W+2)'(n_iss) - (CNT_W+2)'(n_comp);
  end

  // Broadcast registers; tag/data/src hold whenever nothing wins.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cdb_valid     <= 1'b0;
      cdb_tag       <= '0;
      cdb_data      <= '0;
      cdb_src       <= SRC_INT;
      collision_err <= 1'b0;
      inflight_cnt  <= '0;
    end else begin
      collision_err <= collision_err | collision_c;
      if (flush) begin
        cdb_valid    <= 1'b0;
        inflight_cnt <= '0;
      end else begin
        cdb_valid    <= win_valid;
        inflight_cnt <= CNT_W'(cnt_sum);
        if (win_valid) begin
          cdb_tag  <= comp_tag[win_src];
          cdb_data <= comp_data[win_src];
          cdb_src  <= win_src;
        end
      end
    end
  end

  a_cnt_range : assert property (@(posedge clk) disable iff (!rst_b || flush)
    !cnt_sum[CNT_W+1] && (cnt_sum <= (CNT_W+2)'(CNT_MAX)));

endmodule

// File: tb/tb_cdb_writeback.sv
// Self-checking bench for cdb_writeback: directed scenarios plus a randomized run
// compared against a due-cycle list model of in-flight ops.
module tb_cdb_writeback;
  import cdb_pkg::*;

  localparam int unsigned MUL_L = 4;
  localparam int unsigned DIV_L = 6;
  localparam int unsigned TW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 4;

  logic          clk, rst_b, flush;
  logic          issue_div, issue_mul, issue_int, issue_ls;
  logic [TW-1:0] div_tag, mul_tag, int_tag, ls_tag;
  logic [DW-1:0] div_result, mul_result, int_result, ls_result;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [1:0]    cdb_src;
  logic          collision_err;
  logic [CW-1:0] inflight_cnt;

  cdb_writeback #(.NUM_MUL_CYC(MUL_L), .NUM_DIV_CYC(DIV_L), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst_b(rst_b), .flush(flush),
    .issue_div(issue_div), .issue_mul(issue_mul), .issue_int(issue_int), .issue_ls(issue_ls),
    .div_tag(div_tag), .mul_tag(mul_tag), .int_tag(int_tag), .ls_tag(ls_tag),
    .div_result(div_result), .mul_result(mul_result), .int_result(int_result),
    .ls_result(ls_result),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
    .collision_err(collision_err), .inflight_cnt(inflight_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every in-flight op with the absolute cycle it completes in.
  typedef struct {
    int            unit;
    logic [TW-1:0] tag;
    int            due;
  } op_t;

  op_t           pend[$];
  int            cyc;
  int            checks, errors;
  logic          exp_valid, exp_coll;
  logic [TW-1:0] exp_tag;
  logic [DW-1:0] exp_data;
  logic [1:0]    exp_src;
  int            exp_cnt;

  function automatic int lat(input int unit);
    case (unit)
      0:       return int'(DIV_L);
      1:       return int'(MUL_L);
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    pend.delete();
    exp_valid = 1'b0; exp_tag = '0; exp_data = '0; exp_src = 2'(SRC_INT);
    exp_coll = 1'b0; exp_cnt = 0;
  endtask

  // Advance the model over the current cycle's inputs, then clock the DUT.
  task automatic step();
    logic [DW-1:0] res [4];
    logic [TW-1:0] tg  [4];
    logic          iv  [4];
    op_t           keep[$];
    int            win, ncomp;
    logic [TW-1:0] wtag;
    res = '{div_result, mul_result, int_result, ls_result};
    tg  = '{div_tag, mul_tag, int_tag, ls_tag};
    iv  = '{issue_div, issue_mul, issue_int, issue_ls};
    win = -1; ncomp = 0; wtag = '0;
    foreach (pend[k]) begin
      if (pend[k].due == cyc) begin
        ncomp++;
        if (win < 0 || pend[k].unit < win) begin
          win  = pend[k].unit;
          wtag = pend[k].tag;
        end
      end
    end
    if (ncomp > 1) exp_coll = 1'b1;
    if (flush) begin
      pend.delete();
      exp_valid = 1'b0;
    end else begin
      exp_valid = (win >= 0);
      if (win >= 0) begin
        exp_tag  = wtag;
        exp_data = res[win];
        exp_src  = 2'(win);
      end
      foreach (pend[k]) if (pend[k].due != cyc) keep.push_back(pend[k]);
      pend = keep;
      for (int u = 0; u < 4; u++) begin
        if (iv[u]) pend.push_back('{unit: u, tag: tg[u], due: cyc + lat(u)});
      end
    end
    exp_cnt = pend.size();
    @(posedge clk);
    #1;
    cyc++;
    issue_div = 1'b0; issue_mul = 1'b0; issue_int = 1'b0; issue_ls = 1'b0; flush = 1'b0;
    div_result = $urandom; mul_result = $urandom; int_result = $urandom; ls_result = $urandom;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", cdb_valid); end
    if (cdb_tag !== '0) begin errors++; $display("FAIL reset_tag got %0h exp 0", cdb_tag); end
    if (cdb_data !== '0) begin errors++; $display("FAIL reset_data got %0h exp 0", cdb_data); end
    if (cdb_src !== 2'(SRC_INT)) begin errors++; $display("FAIL reset_src got %0d exp 2", cdb_src); end
    if (collision_err !== 1'b0) begin errors++; $display("FAIL reset_coll got %0h exp 0", collision_err); end
    if (inflight_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", inflight_cnt); end
  endtask

  task automatic test_single_int();
    issue_int = 1'b1; int_tag = 6'd5;
    step();
    int_result = 32'hAA;
    step();
    checks += 4;
    if (cdb_valid !== 1'b1) begin errors++; $display("FAIL int_valid got %0h exp 1", cdb_valid); end
    if (cdb_tag !== 6'd5) begin errors++; $display("FAIL int_tag got %0d exp 5", cdb_tag); end
    if (cdb_data !== 32'hAA) begin errors++; $display("FAIL int_data got %0h exp aa", cdb_data); end
    if (cdb_src !== 2'(SRC_INT)) begin errors++; $display("FAIL int_src got %0d exp 2", cdb_src); end
    step();
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL int_valid_drop got %0h exp 0", cdb_valid); end
  endtask

  task automatic test_mul_div();
    int cnt_exp [8] = '{0, 2, 2, 2, 2, 1, 1, 0};
    issue_mul = 1'b1; mul_tag = 6'd3; issue_div = 1'b1; div_tag = 6'd7;
    step();
    for (int i = 1; i <= 7; i++) begin
      checks++;
      if (inflight_cnt !== CW'(cnt_exp[i])) begin
        errors++; $display("FAIL muldiv_cnt cyc %0d got %0d exp %0d", i, inflight_cnt, cnt_exp[i]);
      end
      if (i == 5) begin
        checks += 4;
        if (cdb_valid !== 1'b1) begin errors++; $display("FAIL mul_valid got %0h exp 1", cdb_valid); end
        if (cdb_tag !== 6'd3) begin errors++; $display("FAIL mul_tag got %0d exp 3", cdb_tag); end
        if (cdb_data !== 32'h11) begin errors++; $display("FAIL mul_data got %0h exp 11", cdb_data); end
        if (cdb_src !== 2'(SRC_MUL)) begin errors++; $display("FAIL mul_src got %0d exp 1", cdb_src); end
      end
      if (i == 7) begin
        checks += 5;
        if (cdb_valid !== 1'b1) begin errors++; $display("FAIL div_valid got %0h exp 1", cdb_valid); end
        if (cdb_tag !== 6'd7) begin errors++; $display("FAIL div_tag got %0d exp 7", cdb_tag); end
        if (cdb_data !== 32'h22) begin errors++; $display("FAIL div_data got %0h exp 22", cdb_data); end
        if (cdb_src !== 2'(SRC_DIV)) begin errors++; $display("FAIL div_src got %0d exp 0", cdb_src); end
        if (collision_err !== 1'b0) begin errors++; $display("FAIL muldiv_coll got %0h exp 0", collision_err); end
      end
      if (i == 4) mul_result = 32'h11;
      if (i == 6) div_result = 32'h22;
      step();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 17; i++) begin
      if (i >= 2) begin
        checks += 3;
        if (cdb_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid cyc %0d got %0h exp 1", i, cdb_valid); end
        if (cdb_tag !== 6'(i - 2)) begin errors++; $display("FAIL b2b_tag cyc %0d got %0d exp %0d", i, cdb_tag, i - 2); end
        if (cdb_data !== 32'(32'h100 + i - 2)) begin
          errors++; $display("FAIL b2b_data cyc %0d got %0h exp %0h", i, cdb_data, 32'h100 + i - 2);
        end
      end
      if (i < 16) begin issue_int = 1'b1; int_tag = 6'(i); end
      if (i >= 1 && i <= 16) int_result = 32'(32'h100 + i - 1);
      step();
    end
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got %0h exp 0", cdb_valid); end
  endtask

  task automatic test_flush();
    issue_div = 1'b1; div_tag = 6'd9;
    step(); step(); step();
    flush = 1'b1;
    step();
    checks += 2;
    if (inflight_cnt !== '0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", inflight_cnt); end
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h exp 0", cdb_valid); end
    issue_int = 1'b1; int_tag = 6'd4;
    step();
    int_result = 32'h5A;
    step();
    checks += 2;
    if (cdb_valid !== 1'b1 || cdb_tag !== 6'd4) begin
      errors++; $display("FAIL flush_int got valid %0h tag %0d exp 1/4", cdb_valid, cdb_tag);
    end
    if (cdb_data !== 32'h5A) begin errors++; $display("FAIL flush_int_data got %0h exp 5a", cdb_data); end
    for (int i = 7; i <= 8; i++) begin
      step();
      checks++;
      if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_stale cyc %0d got valid %0h tag %0d", i, cdb_valid, cdb_tag); end
    end
  endtask

  task automatic test_collision();
    issue_div = 1'b1; div_tag = 6'd1;
    step(); step();
    issue_mul = 1'b1; mul_tag = 6'd2;
    for (int i = 2; i <= 5; i++) step();
    checks++;
    if (collision_err !== 1'b0) begin errors++; $display("FAIL coll_early got %0h exp 0", collision_err); end
    div_result = 32'hD1D1;
    step();
    checks += 4;
    if (cdb_valid !== 1'b1 || cdb_tag !== 6'd1) begin
      errors++; $display("FAIL coll_win got valid %0h tag %0d exp 1/1", cdb_valid, cdb_tag);
    end
    if (cdb_src !== 2'(SRC_DIV)) begin errors++; $display("FAIL coll_src got %0d exp 0", cdb_src); end
    if (cdb_data !== 32'hD1D1) begin errors++; $display("FAIL coll_data got %0h exp d1d1", cdb_data); end
    if (collision_err !== 1'b1) begin errors++; $display("FAIL coll_set got %0h exp 1", collision_err); end
    repeat (3) step();
    checks += 2;
    if (collision_err !== 1'b1) begin errors++; $display("FAIL coll_hold got %0h exp 1", collision_err); end
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL coll_loser got valid %0h exp 0", cdb_valid); end
  endtask

  task automatic test_async_reset();
    issue_mul = 1'b1; mul_tag = 6'd12;
    step(); step();
    #3;
    rst_b = 1'b0;
    model_reset();
    #1;
    checks += 5;
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0h exp 0", cdb_valid); end
    if (inflight_cnt !== '0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", inflight_cnt); end
    if (cdb_src !== 2'(SRC_INT)) begin errors++; $display("FAIL arst_src got %0d exp 2", cdb_src); end
    if (cdb_tag !== '0 || cdb_data !== '0) begin
      errors++; $display("FAIL arst_payload got tag %0d data %0h exp 0/0", cdb_tag, cdb_data);
    end
    if (collision_err !== 1'b0) begin errors++; $display("FAIL arst_coll got %0h exp 0", collision_err); end
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    cyc = 3;
    for (int i = 3; i <= 8; i++) begin
      checks++;
      if (cdb_valid !== 1'b0) begin errors++; $display("FAIL arst_stale cyc %0d got %0h exp 0", i, cdb_valid); end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      issue_div = ($urandom_range(0, 5) == 0);
      issue_mul = ($urandom_range(0, 4) == 0);
      issue_int = ($urandom_range(0, 2) == 0);
      issue_ls  = ($urandom_range(0, 3) == 0);
      div_tag = 6'($urandom); mul_tag = 6'($urandom); int_tag = 6'($urandom); ls_tag = 6'($urandom);
      step();
      checks += 6;
      if (cdb_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %0h exp %0h", cyc, cdb_valid, exp_valid); end
      if (cdb_tag !== exp_tag) begin errors++; $display("FAIL rnd_tag cyc %0d got %0d exp %0d", cyc, cdb_tag, exp_tag); end
      if (cdb_data !== exp_data) begin errors++; $display("FAIL rnd_data cyc %0d got %0h exp %0h", cyc, cdb_data, exp_data); end
      if (cdb_src !== exp_src) begin errors++; $display("FAIL rnd_src cyc %0d got %0d exp %0d", cyc, cdb_src, exp_src); end
      if (collision_err !== exp_coll) begin errors++; $display("FAIL rnd_coll cyc %0d got %0h exp %0h", cyc, collision_err, exp_coll); end
      if (inflight_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", cyc, inflight_cnt, exp_cnt); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_b = 1'b0; flush = 1'b0;
    issue_div = 1'b0; issue_mul = 1'b0; issue_int = 1'b0; issue_ls = 1'b0;
    div_tag = '0; mul_tag = '0; int_tag = '0; ls_tag = '0;
    div_result = '0; mul_result = '0; int_result = '0; ls_result = '0;
    test_reset();
    test_single_int();
    test_mul_div();
    test_back_to_back();
    test_flush();
    test_collision();
    do_reset();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
